// File: rtl/ps2_host_tx_pkg.sv
// Shared types and constants for the PS/2 host transmitter: FSM state
// encoding, keyboard command bytes and the odd-parity helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      INHIBIT   = 3'd1,
      REQ       = 3'd2,
      SHIFT     = 3'd3,
      ACK       = 3'd4,
      WAIT_IDLE = 3'd5
   } ps2_state_t;

   localparam logic [7:0] CMD_SET_LEDS = 8'hED;
   localparam logic [7:0] CMD_ECHO     = 8'hEE;
   localparam logic [7:0] CMD_ENABLE   = 8'hF4;
   localparam logic [7:0] CMD_RESET    = 8'hFF;
   localparam logic [7:0] ACK_BYTE     = 8'hFA;

   // Width of the shared inhibit/timeout cycle counter.
   localparam int TCNT_W = 20;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between the system side and the PS/2 host transmitter.
// The system drives the byte and request; the transmitter answers with ready/done/err.
interface ps2_host_tx_if;

   logic [7:0] TX_DATA;
   logic       TX_VALID;
   logic       TX_READY;
   logic       TX_DONE;
   logic       TX_ERR;

   modport master (
      output TX_DATA,
      output TX_VALID,
      input  TX_READY,
      input  TX_DONE,
      input  TX_ERR
   );

   modport slave (
      input  TX_DATA,
      input  TX_VALID,
      output TX_READY,
      output TX_DONE,
      output TX_ERR
   );

endinterface

// File: rtl/ps2_host_tx_line_sync.sv
// Two-flop synchroniser for one PS/2 pin with falling-edge detect; the
// glitch filter is built only when PS2_HOST_TX_CLK_FILTER_EN is defined.
module ps2_line_sync #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_line,
   output logic o_level,
   output logic o_fall
);

   logic r_meta;
   logic r_sync;
   logic r_prev;
   logic w_level;

   // Lines idle high, so every stage resets to 1 to avoid a false fall.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b1;
         r_sync <= 1'b1;
      end else begin
         r_meta <= i_line;
         r_sync <= r_meta;
      end
   end

`ifdef PS2_HOST_TX_CLK_FILTER_EN
   localparam int FCNT_W = $clog2(FILTER_LEN + 1);

   logic [FCNT_W-1:0] r_fcnt;
   logic              r_filt;

   // Output follows the synced line only after FILTER_LEN samples in a row disagree with it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_fcnt <= '0;
         r_filt <= 1'b1;
      end else if (r_sync == r_filt) begin
         r_fcnt <= '0;
      end else if (r_fcnt == FCNT_W'(FILTER_LEN - 1)) begin
         r_filt <= r_sync;
         r_fcnt <= '0;
      end else begin
         r_fcnt <= r_fcnt + 1'b1;
      end
   end

   assign w_level = r_filt;
`else
   assign w_level = r_sync;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_prev <= 1'b1;
      end else begin
         r_prev <= w_level;
      end
   end

   assign o_level = w_level;
   assign o_fall  = r_prev & ~w_level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter with open-drain pull-low enables.
// Optional clock glitch filter: define PS2_HOST_TX_CLK_FILTER_EN.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 5000,
   parameter int TIMEOUT_CYCLES = 850000,
   parameter int FILTER_LEN     = 8
) (
   input  logic                 CLK,
   input  logic                 RESETN,
   ps2_host_tx_if.slave         tx,
   input  logic                 PS2_CLK_IN,
   input  logic                 PS2_DATA_IN,
   output logic                 PS2_CLK_OE,
   output logic                 PS2_DATA_OE,
   output logic                 BUS_OWNED
);

   localparam logic [TCNT_W-1:0] INH_LAST = TCNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [TCNT_W-1:0] TO_LAST  = TCNT_W'(TIMEOUT_CYCLES - 1);

   logic w_clk_lvl;
   logic w_clk_fall;
   logic w_data_lvl;
   logic w_data_fall_unused;

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
      .clk     (CLK),
      .rst_n   (RESETN),
      .i_line  (PS2_CLK_IN),
      .o_level (w_clk_lvl),
      .o_fall  (w_clk_fall)
   );

   ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_data_sync (
      .clk     (CLK),
      .rst_n   (RESETN),
      .i_line  (PS2_DATA_IN),
      .o_level (w_data_lvl),
      .o_fall  (w_data_fall_unused)
   );

   ps2_state_t        r_state;
   logic [7:0]        r_data;
   logic              r_par;
   logic [TCNT_W-1:0] r_cnt;
   logic [3:0]        r_bitcnt;
   logic              r_nack;
   logic              r_clk_oe;
   logic              r_data_oe;
   logic              r_ready;
   logic              r_bus;
   logic              r_done;
   logic              r_err;

   // r_cnt times the inhibit period, then is reused as the transfer watchdog.
   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state   <= IDLE;
         r_data    <= '0;
         r_par     <= 1'b0;
         r_cnt     <= '0;
         r_bitcnt  <= '0;
         r_nack    <= 1'b0;
         r_clk_oe  <= 1'b0;
         r_data_oe <= 1'b0;
         r_ready   <= 1'b1;
         r_bus     <= 1'b0;
         r_done    <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (tx.TX_VALID && r_ready) begin
                  r_data   <= tx.TX_DATA;
                  r_par    <= odd_parity(tx.TX_DATA);
                  r_cnt    <= '0;
                  r_err    <= 1'b0;
                  r_ready  <= 1'b0;
                  r_bus    <= 1'b1;
                  r_clk_oe <= 1'b1;
                  r_state  <= INHIBIT;
               end else begin
                  r_ready <= 1'b1;
               end
            end

            INHIBIT: begin
               if (r_cnt == INH_LAST) begin
                  r_data_oe <= 1'b1;
                  r_state   <= REQ;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end

            REQ: begin
               r_clk_oe <= 1'b0;
               r_cnt    <= '0;
               r_bitcnt <= '0;
               r_state  <= SHIFT;
            end

            SHIFT, ACK, WAIT_IDLE: begin
               if (r_cnt == TO_LAST) begin
                  r_clk_oe  <= 1'b0;
                  r_data_oe <= 1'b0;
                  r_done    <= 1'b1;
                  r_err     <= 1'b1;
                  r_bus     <= 1'b0;
                  r_state   <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
                  if (r_state == SHIFT) begin
                     // Host changes data while the device holds clock low.
                     if (w_clk_fall) begin
                        if (r_bitcnt < 4'd8) begin
                           r_data_oe <= ~r_data[r_bitcnt[2:0]];
                        end else if (r_bitcnt == 4'd8) begin
                           r_data_oe <= ~r_par;
                        end else begin
                           r_data_oe <= 1'b0;
                           r_state   <= ACK;
                        end
                        r_bitcnt <= r_bitcnt + 1'b1;
                     end
                  end else if (r_state == ACK) begin
                     if (w_clk_fall) begin
                        r_nack  <= w_data_lvl;
                        r_state <= WAIT_IDLE;
                     end
                  end else if (w_clk_lvl && w_data_lvl) begin
                     r_done  <= 1'b1;
                     r_err   <= r_nack;
                     r_bus   <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end

            default: begin
               r_clk_oe  <= 1'b0;
               r_data_oe <= 1'b0;
               r_bus     <= 1'b0;
               r_state   <= IDLE;
            end
         endcase
      end
   end

   assign tx.TX_READY = r_ready;
   assign tx.TX_DONE  = r_done;
   assign tx.TX_ERR   = r_err;
   assign PS2_CLK_OE  = r_clk_oe;
   assign PS2_DATA_OE = r_data_oe;
   assign BUS_OWNED   = r_bus;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a table of command bytes sent to a simple
// keyboard model, plus timeout and mid-transfer reset sequences.
`timescale 1ns/1ps
module tb_ps2_host_tx;

   localparam int INH = 5000;
   localparam int TO  = 3000;
   localparam int H   = 20;

   typedef struct {
      logic [7:0] data;
      bit         ack;
      bit         poke;
      bit         glitch;
      logic [9:0] frame;
      bit         err;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic dev_clk_low = 1'b0;
   logic dev_data_low = 1'b0;
   logic clk_oe, data_oe, bus_owned;
   wire  clk_line  = ~(clk_oe | dev_clk_low);
   wire  data_line = ~(data_oe | dev_data_low);

   int checks = 0;
   int failures = 0;
   vec_t vecs[5];

   ps2_host_tx_if tx_if();

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES(INH),
      .TIMEOUT_CYCLES(TO),
      .FILTER_LEN(8)
   ) dut (
      .CLK         (clk),
      .RESETN      (rst_n),
      .tx          (tx_if),
      .PS2_CLK_IN  (clk_line),
      .PS2_DATA_IN (data_line),
      .PS2_CLK_OE  (clk_oe),
      .PS2_DATA_OE (data_oe),
      .BUS_OWNED   (bus_owned)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Accept one byte, follow the inhibit/request phase, then clock the frame
   // as a keyboard would. abort_k >= 0 stops right after that rising edge.
   task automatic run_xfer(input vec_t v, input int abort_k);
      int n;
      int rem;
      logic [9:0] frame;
      frame = '0;
      @(negedge clk);
      tx_if.TX_DATA  = v.data;
      tx_if.TX_VALID = 1'b1;
      @(negedge clk);
      tx_if.TX_VALID = 1'b0;
      tx_if.TX_DATA  = 8'h00;
      check("accept_ready_bus", 32'({tx_if.TX_READY, bus_owned}), 1);
      n = 0;
      while (clk_oe && n < INH + 100) begin
         n++;
         @(negedge clk);
      end
      // Inhibit cycles plus the one request cycle keep the clock pulled low.
      check("clk_oe_low_len", n, INH + 1);
      check("start_bit", 32'(data_line), 0);
      repeat (H) @(negedge clk);
      for (int k = 0; k <= 10; k++) begin
         dev_clk_low = 1'b1;
         if (k == 10 && v.ack) dev_data_low = 1'b1;
         repeat (H) @(negedge clk);
         dev_clk_low = 1'b0;
         if (k < 10) frame[k] = data_line;
         if (k == abort_k) return;
         if (k == 10) begin
            dev_data_low = 1'b0;
         end else begin
            rem = H;
            if (k == 2 && v.poke) begin
               tx_if.TX_DATA  = 8'h55;
               tx_if.TX_VALID = 1'b1;
               @(negedge clk);
               tx_if.TX_VALID = 1'b0;
               tx_if.TX_DATA  = 8'h00;
               rem = rem - 1;
            end
            if (k == 3 && v.glitch) begin
               repeat (5) @(negedge clk);
               dev_clk_low = 1'b1;
               repeat (3) @(negedge clk);
               dev_clk_low = 1'b0;
               rem = rem - 8;
            end
            repeat (rem) @(negedge clk);
         end
      end
      n = 0;
      while (!tx_if.TX_DONE && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("done_pulse", 32'(tx_if.TX_DONE), 1);
      check("tx_err", 32'(tx_if.TX_ERR), 32'(v.err));
      check("frame_bits", 32'(frame), 32'(v.frame));
      check("lines_at_done", 32'({clk_oe, data_oe, bus_owned, tx_if.TX_READY}), 0);
      @(negedge clk);
      check("ready_after_done", 32'({tx_if.TX_READY, tx_if.TX_DONE}), 2);
      n = 0;
      repeat (30) begin
         @(negedge clk);
         if (clk_oe || bus_owned) n++;
      end
      check("no_queued_xfer", n, 0);
      $display("xfer data=%02h frame=%03h err=%0b", v.data, frame, tx_if.TX_ERR);
   endtask

   initial begin
      int n;
      // {data, ack, poke, glitch, frame={stop,parity,data}, err}
      vecs[0] = '{8'hED, 1'b1, 1'b1, 1'b0, 10'h3ED, 1'b0};
      vecs[1] = '{8'hF4, 1'b1, 1'b0, 1'b0, 10'h2F4, 1'b0};
      vecs[2] = '{8'h00, 1'b1, 1'b0, 1'b0, 10'h300, 1'b0};
      vecs[3] = '{8'hFF, 1'b0, 1'b0, 1'b0, 10'h3FF, 1'b1};
      vecs[4] = '{8'hEE, 1'b1, 1'b0, 1'b0, 10'h3EE, 1'b0};
`ifdef PS2_HOST_TX_CLK_FILTER_EN
      vecs[1].glitch = 1'b1;
`endif
      tx_if.TX_DATA  = 8'h00;
      tx_if.TX_VALID = 1'b0;

      repeat (3) @(negedge clk);
      check("reset_ready", 32'(tx_if.TX_READY), 1);
      check("reset_outputs", 32'({clk_oe, data_oe, bus_owned, tx_if.TX_DONE, tx_if.TX_ERR}), 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 4; i++) run_xfer(vecs[i], -1);

      // Device never clocks: watchdog must end the transfer.
      @(negedge clk);
      tx_if.TX_DATA  = 8'hF4;
      tx_if.TX_VALID = 1'b1;
      @(negedge clk);
      tx_if.TX_VALID = 1'b0;
      n = 0;
      while (clk_oe && n < INH + 100) begin
         n++;
         @(negedge clk);
      end
      n = 0;
      while (!tx_if.TX_DONE && n < TO + 50) begin
         @(negedge clk);
         n++;
      end
      check("timeout_cycles", n, TO);
      check("timeout_err", 32'(tx_if.TX_ERR), 1);
      check("timeout_lines", 32'({clk_oe, data_oe, bus_owned, tx_if.TX_READY}), 0);
      @(negedge clk);
      check("timeout_ready", 32'(tx_if.TX_READY), 1);
      $display("xfer data=f4 timeout after %0d cycles", n);

      // Reset in the middle of the data bits drops the drivers immediately.
      run_xfer(vecs[0], 4);
      check("data_oe_before_reset", 32'(data_oe), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_reset_lines", 32'({clk_oe, data_oe, bus_owned}), 0);
      check("async_reset_ready", 32'(tx_if.TX_READY), 1);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", 32'(tx_if.TX_READY), 1);
      $display("xfer data=ed aborted by reset");
      run_xfer(vecs[4], -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
Host-to-device PS/2 transmitter that sends one command byte, such as 0xED set-LEDs or 0xFF reset, to the keyboard on the same PS2_CLK/PS2_DATA pair used by the keyboard receive path. It runs the inhibit/request-to-send sequence, shifts out data, parity and stop bits on device-generated clock edges, then checks the device acknowledge bit. Pad drive is open-drain: the outputs are active-high pull-low enables. BUS_OWNED tells the receive path to ignore bus activity while a transfer is in progress.

Parameters:
INHIBIT_CYCLES, 5000, CLK cycles PS2_CLK is held low before the request (100 us at 50 MHz)
TIMEOUT_CYCLES, 850000, maximum CLK cycles from clock release to bus-idle (17 ms at 50 MHz); counter is 20 bits
FILTER_LEN, 8, consecutive equal samples required by the optional clock filter

Ports:
CLK  in  1  system clock; single clock domain
RESETN  in  1  asynchronous, active-low reset
TX_DATA  in  8  byte to send
TX_VALID  in  1  request; accepted when TX_VALID and TX_READY are both 1
TX_READY  out  1  high only in IDLE
PS2_CLK_IN  in  1  raw keyboard clock pin (asynchronous)
PS2_DATA_IN  in  1  raw keyboard data pin (asynchronous)
PS2_CLK_OE  out  1  1 = pull PS2_CLK low
PS2_DATA_OE  out  1  1 = pull PS2_DATA low
BUS_OWNED  out  1  high in every state except IDLE
TX_DONE  out  1  one-cycle pulse at the end of every accepted transfer
TX_ERR  out  1  valid with TX_DONE; 1 = NACK or timeout

Behaviour:
- Reset values: all outputs 0 except TX_READY=1. State IDLE. Both OE outputs drop asynchronously when RESETN goes low, including mid-transfer.
- Synchronisation: PS2_CLK_IN and PS2_DATA_IN pass through 2-FF synchronisers. "fall" = synced clock was 1 on the previous cycle and is 0 now, so it lags the pin by 2-3 cycles.
- Parity: par = ~^data (odd parity), computed from the byte latched at accept.
- IDLE: on accept, latch TX_DATA and par, then go to INHIBIT on the next cycle.
- INHIBIT: CLK_OE=1 for exactly INHIBIT_CYCLES cycles, then go to REQ.
- REQ (1 cycle): CLK_OE=1 and DATA_OE=1, which forms the start bit. Then go to SHIFT and clear the timeout counter.
- SHIFT: CLK_OE=0; bit counter starts at 0.
  - On each fall, the counter advances and DATA_OE is set as follows: counts 0-7 → ~data[count], LSB first; count 8 → ~par; count 9 → 0 (stop bit, line released).
  - After count 9 is applied, go to ACK.
- ACK: on the next fall, sample the synced data. 0 = ACK (err=0); 1 = NACK (err=1). Then go to WAIT_IDLE.
- WAIT_IDLE: wait until both synced lines are 1. Then pulse TX_DONE with TX_ERR=err and return to IDLE. TX_READY rises on the cycle after TX_DONE.
- Timeout: the counter runs in SHIFT, ACK and WAIT_IDLE. When it reaches TIMEOUT_CYCLES:
  - both OE outputs go to 0;
  - TX_DONE=1 and TX_ERR=1;
  - state returns to IDLE.
- TX_VALID outside IDLE is ignored and is not queued.
- A fall during INHIBIT or REQ is ignored.
- The block never drives a line high.

Optional Feature:
- Macro PS2_HOST_TX_CLK_FILTER_EN.
- When defined: the synced clock feeds a filter whose output changes only after FILTER_LEN consecutive identical samples. "fall" is taken from the filtered clock, which adds FILTER_LEN cycles of latency.
- When undefined: "fall" comes directly from the 2-FF synced clock.

Decomposition:
- Package ps2_pkg holds:
  - the state enum: IDLE, INHIBIT, REQ, SHIFT, ACK, WAIT_IDLE;
  - command constants: CMD_SET_LEDS=8'hED, CMD_ECHO=8'hEE, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF;
  - ACK_BYTE=8'hFA.
- Sub-module ps2_line_sync (2-FF synchroniser, optional filter, fall detect) is instantiated for the clock and for data. The data instance does not use the fall output.

Test Plan:
- Normal transfer: send 0xED; device model ACKs.
  - CLK_OE is high for 5000 cycles; then the start bit is 0.
  - Bits sampled on rising edges are 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Result: TX_DONE=1, TX_ERR=0.
- Parity check: send 0xF4 → parity 0 sampled. Send 0x00 → parity 1 sampled.
- NACK: send 0xFF; device leaves data high at the ack clock → TX_DONE=1, TX_ERR=1, both OE=0.
- Timeout: device never clocks → exactly TIMEOUT_CYCLES cycles after SHIFT entry, TX_DONE=1, TX_ERR=1, OE=0, TX_READY=1 one cycle later.
- Reset mid-transfer: assert RESETN=0 after data bit 4 → both OE drop in the same cycle without waiting for a clock edge. After release, TX_READY=1 and a new 0xEE transfer completes with TX_ERR=0.
- Busy and filter:
  - Pulse TX_VALID with 0x55 during SHIFT → it is never transmitted.
  - With the macro defined, a 3-cycle low glitch on PS2_CLK_IN does not advance the bit counter.
